// File: rtl/inst_cache_ctrl.sv
// inst_cache_ctrl: direct-mapped instruction cache that hands the IFQ one
// 4-word line per hit. Lookup is combinational, and a miss starts a 4-beat
// line fill from instruction memory.
//
// Ports
//   Clk, Resetb        clock, synchronous active-low reset
//   Ifetch_WpPcIn      line address from the IFQ (bits [3:0] are zero)
//   Ifetch_ReadCache   the IFQ requests a line this cycle
//   IFQ_Flush          the IFQ is flushing; this has no effect on lookup or fill
//   Cache_Cd0..Cd3     words 0..3 of the indexed line (combinational)
//   Cache_ReadHit      Cd0..Cd3 are valid for Ifetch_WpPcIn (combinational)
//   Mem_Req/Mem_Addr   line-fill request and line base address (registered)
//   Mem_Ack            memory accepted the request
//   Mem_Rdata/Rvalid   fill data beats, word 0 first
//   Cache_MissCnt      saturating count of fills started
module inst_cache_ctrl #(
    parameter int unsigned INDEX_BITS = 5
) (
    input  logic        Clk,
    input  logic        Resetb,
    input  logic [31:0] Ifetch_WpPcIn,
    input  logic        Ifetch_ReadCache,
    input  logic        IFQ_Flush,
    output logic [31:0] Cache_Cd0,
    output logic [31:0] Cache_Cd1,
    output logic [31:0] Cache_Cd2,
    output logic [31:0] Cache_Cd3,
    output logic        Cache_ReadHit,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Rdata,
    input  logic        Mem_Rvalid,
    output logic [15:0] Cache_MissCnt
);

    localparam int unsigned TAG_BITS = 32 - 4 - INDEX_BITS;
    localparam int unsigned LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t               state_q;
    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_ram  [LINES];
    logic [127:0]         data_ram [LINES];
    logic [27:0]          fill_line_q;
    logic [1:0]           beat_q;
    logic [31:0]          fill_buf_q [4];
    logic                 mem_req_q;
    logic [15:0]          miss_cnt_q;

    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   tag;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [127:0]          rd_line;
    logic                  lookup_hit;
    logic                  start_fill;

    // Byte offset bits and the flush input are intentionally not consumed.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, Ifetch_WpPcIn[3:0], IFQ_Flush};

    assign idx      = Ifetch_WpPcIn[4 +: INDEX_BITS];
    assign tag      = Ifetch_WpPcIn[31 -: TAG_BITS];
    assign fill_idx = fill_line_q[0 +: INDEX_BITS];
    assign fill_tag = fill_line_q[27 -: TAG_BITS];

    // Hit path deliberately excludes IFQ_Flush and Mem_* to avoid a loop through the IFQ.
    assign lookup_hit    = valid_q[idx] && (tag_ram[idx] == tag);
    assign Cache_ReadHit = Ifetch_ReadCache && (state_q == S_IDLE) && lookup_hit;
    assign start_fill    = Ifetch_ReadCache && (state_q == S_IDLE) && !lookup_hit;

    assign rd_line   = data_ram[idx];
    assign Cache_Cd0 = rd_line[31:0];
    assign Cache_Cd1 = rd_line[63:32];
    assign Cache_Cd2 = rd_line[95:64];
    assign Cache_Cd3 = rd_line[127:96];

    assign Mem_Req       = mem_req_q;
    assign Mem_Addr      = {fill_line_q, 4'b0000};
    assign Cache_MissCnt = miss_cnt_q;

    // Line-fill FSM and control state.
    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            beat_q      <= 2'd0;
            miss_cnt_q  <= 16'd0;
            mem_req_q   <= 1'b0;
            fill_line_q <= 28'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_fill) begin
                        fill_line_q <= Ifetch_WpPcIn[31:4];
                        beat_q      <= 2'd0;
                        mem_req_q   <= 1'b1;
                        state_q     <= S_REQ;
                        if (miss_cnt_q != 16'hFFFF) begin
                            miss_cnt_q <= miss_cnt_q + 16'd1;
                        end
                    end
                end
                S_REQ: begin
                    if (Mem_Ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (Mem_Rvalid) begin
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            valid_q[fill_idx] <= 1'b1;
                            state_q           <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Fill buffer and tag/data arrays; no reset, and writes are blocked while in reset.
    always_ff @(posedge Clk) begin
        if (Resetb && (state_q == S_FILL) && Mem_Rvalid) begin
            fill_buf_q[beat_q] <= Mem_Rdata;
            if (beat_q == 2'd3) begin
                data_ram[fill_idx] <= {Mem_Rdata, fill_buf_q[2], fill_buf_q[1], fill_buf_q[0]};
                tag_ram[fill_idx]  <= fill_tag;
            end
        end
    end

endmodule
